// File: rtl/wb_slave_mem_pkg.sv
// Shared types and helpers for the wb_slave_mem Wishbone classic slave.
// Optional transfer statistics are enabled by WB_SLAVE_MEM_STATS_EN.
package wb_slave_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic int sel_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int off_w(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/wb_slave_mem_ram.sv
// DEPTH x DATA_W storage with per-byte-lane write enables and a registered
// read port; the array itself is never reset, only the read register.
module wb_slave_mem_ram
  import wb_slave_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [sel_w(DATA_W)-1:0]  sel,
  input  logic                      re,
  input  logic                      clr,
  input  logic [AW-1:0]             addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata
);

  localparam int SEL_W = sel_w(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (we && sel[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave memory: wait states, byte lanes, error on range miss.
// Define WB_SLAVE_MEM_STATS_EN to build the saturating transfer counters.
module wb_slave_mem
  import wb_slave_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [ADDR_W-1:0]         wbs_adr_i,
  input  logic [DATA_W-1:0]         wbs_dat_i,
  output logic [DATA_W-1:0]         wbs_dat_o,
  input  logic                      wbs_we_i,
  input  logic [sel_w(DATA_W)-1:0]  wbs_sel_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  output logic                      wbs_ack_o,
  output logic                      wbs_err_o,
  output logic [31:0]               rd_cnt_o,
  output logic [31:0]               wr_cnt_o,
  output logic [31:0]               err_cnt_o
);

  localparam int OFF_W  = off_w(DATA_W);
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  state_t            nxt;
  logic [3:0]        wcnt;
  logic [3:0]        wcnt_nxt;
  logic              resp_err;
  logic              req;
  logic              go_resp;
  logic              in_range;
  logic [ADDR_W-1:0] idx;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign idx      = wbs_adr_i >> OFF_W;
  assign in_range = idx < ADDR_W'(DEPTH);
  assign go_resp  = (nxt == RESP);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      wcnt     <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= nxt;
      wcnt  <= wcnt_nxt;
      if (go_resp) begin
        resp_err <= ~in_range;
      end
    end
  end

  always_comb begin
    nxt      = state;
    wcnt_nxt = wcnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            nxt = RESP;
          end else begin
            nxt      = WAIT;
            wcnt_nxt = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        // A dropped strobe abandons the transfer before anything commits
        if (!req) begin
          nxt      = IDLE;
          wcnt_nxt = '0;
        end else if (wcnt == '0) begin
          nxt = RESP;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o = 1'b0;
    wbs_err_o = 1'b0;
    if (state == RESP) begin
      wbs_ack_o = ~resp_err;
      wbs_err_o = resp_err;
    end
  end

  wb_slave_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .we    (go_resp & in_range & wbs_we_i & ~wb_rst_i),
    .sel   (wbs_sel_i),
    .re    (go_resp & in_range & ~wbs_we_i),
    .clr   (go_resp & ~in_range),
    .addr  (idx[RAM_AW-1:0]),
    .wdata (wbs_dat_i),
    .rdata (wbs_dat_o)
  );

`ifdef WB_SLAVE_MEM_STATS_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_cnt_o  <= '0;
      wr_cnt_o  <= '0;
      err_cnt_o <= '0;
    end else if (go_resp) begin
      if (!in_range) begin
        if (err_cnt_o != CNT_MAX) err_cnt_o <= err_cnt_o + 32'd1;
      end else if (wbs_we_i) begin
        if (wr_cnt_o != CNT_MAX) wr_cnt_o <= wr_cnt_o + 32'd1;
      end else begin
        if (rd_cnt_o != CNT_MAX) rd_cnt_o <= rd_cnt_o + 32'd1;
      end
    end
  end
`else
  assign rd_cnt_o  = '0;
  assign wr_cnt_o  = '0;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: one slave with no wait states, one with three,
// checked every cycle against a transaction-level model.
module tb_wb_slave_mem;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic [31:0] adr  [2];
  logic [31:0] dati [2];
  logic [31:0] dato [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic        stb  [2];
  logic        cyc  [2];
  logic        ack  [2];
  logic        err  [2];
  logic [31:0] rdc  [2];
  logic [31:0] wrc  [2];
  logic [31:0] erc  [2];

  wb_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(dati[0]),
    .wbs_dat_o(dato[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_stb_i(stb[0]),
    .wbs_cyc_i(cyc[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]),
    .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0]), .err_cnt_o(erc[0])
  );

  wb_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(dati[1]),
    .wbs_dat_o(dato[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_stb_i(stb[1]),
    .wbs_cyc_i(cyc[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]),
    .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1]), .err_cnt_o(erc[1])
  );

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Transaction-level model state
  int          cycnt = 0;
  int          exp_cyc [2] = '{-1, -1};
  bit          p_we    [2];
  bit          p_err   [2];
  logic [31:0] p_dat   [2];
  bit          e_ack   [2];
  bit          e_err   [2];
  logic [31:0] e_dat   [2];
  int unsigned e_rd    [2];
  int unsigned e_wr    [2];
  int unsigned e_er    [2];
  logic [31:0] mm [int];

  bit chk_en = 1'b0;
  int n_chk  = 0;
  int n_fail = 0;
  int resp_cyc [2] = '{0, 0};
  int pulses   [2] = '{0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cycnt <= cycnt + 1;
    for (int d = 0; d < 2; d++) begin
      e_ack[d] <= 1'b0;
      e_err[d] <= 1'b0;
      if (rst[d]) begin
        e_dat[d] <= '0;
        e_rd[d]  <= 0;
        e_wr[d]  <= 0;
        e_er[d]  <= 0;
      end else if (cycnt + 1 == exp_cyc[d]) begin
        if (p_err[d]) begin
          e_err[d] <= 1'b1;
          e_dat[d] <= '0;
          e_er[d]  <= e_er[d] + 1;
        end else begin
          e_ack[d] <= 1'b1;
          if (p_we[d]) begin
            e_wr[d] <= e_wr[d] + 1;
          end else begin
            e_dat[d] <= p_dat[d];
            e_rd[d]  <= e_rd[d] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d ack", d), 32'(ack[d]), 32'(e_ack[d]));
        chk($sformatf("d%0d err", d), 32'(err[d]), 32'(e_err[d]));
        chk($sformatf("d%0d dat_o", d), dato[d], e_dat[d]);
`ifdef WB_SLAVE_MEM_STATS_EN
        chk($sformatf("d%0d rd_cnt", d), rdc[d], e_rd[d]);
        chk($sformatf("d%0d wr_cnt", d), wrc[d], e_wr[d]);
        chk($sformatf("d%0d err_cnt", d), erc[d], e_er[d]);
`else
        chk($sformatf("d%0d rd_cnt", d), rdc[d], 32'd0);
        chk($sformatf("d%0d wr_cnt", d), wrc[d], 32'd0);
        chk($sformatf("d%0d err_cnt", d), erc[d], 32'd0);
`endif
        if (ack[d] === 1'b1 || err[d] === 1'b1) begin
          resp_cyc[d] = cycnt;
          pulses[d]++;
        end
      end
    end
  end

  task automatic xfer(input int d, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s);
    int k;
    int p0;
    int key;
    logic [31:0] word;
    @(posedge clk);
    #1;
    adr[d] = a; dati[d] = wd; we[d] = w; sel[d] = s;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    k  = cycnt;
    p0 = pulses[d];
    key = d * 4096 + int'(a >> 2);
    p_we[d]  = w;
    p_err[d] = (a >> 2) >= DEPTH;
    if (!p_err[d]) begin
      word = mm.exists(key) ? mm[key] : 32'h0;
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) word[8*i +: 8] = wd[8*i +: 8];
        mm[key] = word;
      end
      p_dat[d] = word;
    end
    exp_cyc[d] = k + 1 + ws(d);
    repeat (1 + ws(d)) @(posedge clk);
    #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk);
    chk($sformatf("d%0d single response", d), 32'(pulses[d] - p0), 32'd1);
    chk($sformatf("d%0d latency", d), 32'(resp_cyc[d] - k), (d == 0) ? 32'd1 : 32'd4);
  endtask

  task automatic abort_xfer(input int d, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    adr[d] = a; dati[d] = wd; we[d] = 1'b1; sel[d] = 4'hF;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);
    #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic reset_in_wait(input int d, input logic [31:0] a);
    @(posedge clk);
    #1;
    adr[d] = a; we[d] = 1'b0; sel[d] = 4'hF;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);
    #1;
    rst[d] = 1'b1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; adr[d] = '0; dati[d] = '0; we[d] = 1'b0;
      sel[d] = '0; stb[d] = 1'b0; cyc[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    chk("reset dat_o d0", dato[0], 32'h0);
    chk("reset dat_o d1", dato[1], 32'h0);

    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);
    chk("full word read", dato[0], 32'hDEADBEEF);

    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF);
    chk("byte lanes", dato[0], 32'h11BB33DD);

    xfer(0, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF);
    xfer(0, 1'b0, 32'h100, 32'h0, 4'hF);
    chk("err read dat", dato[0], 32'h0);
    xfer(0, 1'b1, 32'h100, 32'h55555555, 4'hF);
    xfer(0, 1'b0, 32'hFC, 32'h0, 4'hF);
    chk("last word intact", dato[0], 32'hCAFEF00D);

    xfer(0, 1'b1, 32'h10, 32'h0, 4'h0);
    xfer(0, 1'b0, 32'h13, 32'h0, 4'hF);
    chk("sel0 nop and offset", dato[0], 32'hDEADBEEF);

    xfer(1, 1'b1, 32'h40, 32'h12345678, 4'hF);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF);
    chk("wait-state read", dato[1], 32'h12345678);

    abort_xfer(1, 32'h40, 32'hFFFFFFFF);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF);
    chk("abort no write", dato[1], 32'h12345678);

    reset_in_wait(1, 32'h40);
    chk("rst clears dat", dato[1], 32'h0);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF);
    chk("mem survives rst", dato[1], 32'h12345678);
`ifdef WB_SLAVE_MEM_STATS_EN
    chk("rd_cnt after rst", rdc[1], 32'd1);
    chk("wr_cnt after rst", wrc[1], 32'd0);
    chk("d0 err_cnt", erc[0], 32'd2);
`else
    chk("rd_cnt tied", rdc[1], 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
